// File: rtl/fm_pkg.sv
// fm_pkg: shared constants and helpers for the 3x3 feature-map window generator.
//   PAD_VALID / PAD_SAME : padding-mode selectors for featuremap_window_gen.
//   TAP_TL .. TAP_BR     : tap indices, j = 3*dy + dx (0 = top-left, 8 = bottom-right).
//   fm_state_e           : flush FSM states.
//   fm_tap_off()         : bit offset of (channel, tap) inside window_out.
package fm_pkg;

  localparam int PAD_VALID = 0;
  localparam int PAD_SAME  = 1;

  localparam int TAP_TL = 0;
  localparam int TAP_TM = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BM = 7;
  localparam int TAP_BR = 8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fm_state_e;

  function automatic int fm_tap_off(input int ch, input int tap, input int dw);
    return (ch * 9 + tap) * dw;
  endfunction

endpackage

// File: rtl/fm_line_buffer.sv
// fm_line_buffer: DEPTH-beat delay line over WIDTH-bit words.
//   Clk    : clock, rising edge
//   Rst    : synchronous active-high reset (clears the pointer only)
//   i_en   : advance; writes i_data and steps the circular pointer
//   i_data : word entering the line
//   o_data : word written DEPTH enables ago (read combinationally at the pointer)
module fm_line_buffer #(
  parameter int DEPTH = 104,
  parameter int WIDTH = 1024
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;

  // The slot about to be overwritten holds the oldest word.
  assign o_data = r_mem[r_ptr];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

  // Contents need no reset: stale words only reach taps that are masked or not emitted.
  always_ff @(posedge Clk) begin
    if (i_en) r_mem[r_ptr] <= i_data;
  end

endmodule

// File: rtl/featuremap_window_gen.sv
// featuremap_window_gen: multi-channel 3x3 sliding-window generator.
//   Clk        : clock, rising edge
//   Rst        : synchronous active-high reset
//   data_in    : one raster pixel, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   valid_in   : pixel present; taken when valid_in && in_ready
//   in_ready   : low only during the same-mode end-of-frame flush
//   window_out : tap j of channel k at [(k*9+j)*DATA_WIDTH +: DATA_WIDTH]
//   valid_out  : window_out valid (one cycle per window)
//   frame_done : high with the last window of a frame
module featuremap_window_gen
  import fm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 32,
  parameter int IMG_SIZE   = 104,
  parameter int PAD_MODE   = 1
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           valid_in,
  output logic                           in_ready,
  output logic [CHANNELS*9*DATA_WIDTH-1:0] window_out,
  output logic                           valid_out,
  output logic                           frame_done
);

  localparam int N    = IMG_SIZE;
  localparam int PW   = CHANNELS * DATA_WIDTH;
  localparam int WW   = CHANNELS * 9 * DATA_WIDTH;
  localparam int CW   = $clog2(N + 1);
  localparam bit SAME = (PAD_MODE == PAD_SAME);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  fm_state_e r_state, w_state_nxt;

  // Input raster position. During flush r_row sits at N and r_col counts the
  // N+1 virtual zero pixels, so it doubles as the flush counter.
  logic [CW-1:0] r_row, r_col;

  logic          w_acc, w_flush, w_adv;
  logic [PW-1:0] w_pix, w_lb1, w_lb2;
  logic [2:0][1:0][PW-1:0] r_sh;     // [dy][dx] for dx = 0,1; dx = 2 is the live column
  logic [2:0][2:0][PW-1:0] w_grid;
  logic [2:0][PW-1:0]      w_col;

  logic          w_qv, w_emit, w_last;
  logic [CW-1:0] w_cr, w_cc;
  logic          w_top, w_bot, w_lft, w_rgt;
  logic [8:0]    w_mask;
  logic [WW-1:0] w_win;

  assign in_ready = (r_state == ST_RUN);
  assign w_acc    = valid_in && in_ready;
  assign w_flush  = (r_state == ST_FLUSH);
  assign w_adv    = w_acc || w_flush;
  assign w_pix    = w_flush ? '0 : data_in;

  // ---------------- flush FSM ----------------
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (SAME && w_acc && r_row == LAST && r_col == LAST) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_col == CW'(N)) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // ---------------- raster counters ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_adv) begin
      if (w_flush) begin
        if (r_col == CW'(N)) begin
          r_row <= '0;
          r_col <= '0;
        end else begin
          r_col <= r_col + CW'(1);
        end
      end else if (r_col == LAST) begin
        r_col <= '0;
        if (r_row == LAST) r_row <= SAME ? CW'(N) : '0;
        else               r_row <= r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // ---------------- line buffers: delays of N and 2N beats ----------------
  fm_line_buffer #(.DEPTH(N), .WIDTH(PW)) u_lb1 (
    .Clk(Clk), .Rst(Rst), .i_en(w_adv), .i_data(w_pix), .o_data(w_lb1)
  );

  fm_line_buffer #(.DEPTH(N), .WIDTH(PW)) u_lb2 (
    .Clk(Clk), .Rst(Rst), .i_en(w_adv), .i_data(w_lb1), .o_data(w_lb2)
  );

  // New column entering the window: top = p-2N, middle = p-N, bottom = p.
  assign w_col[0] = w_lb2;
  assign w_col[1] = w_lb1;
  assign w_col[2] = w_pix;

  always_ff @(posedge Clk) begin
    if (w_adv) begin
      for (int dy = 0; dy < 3; dy++) begin
        r_sh[dy][0] <= r_sh[dy][1];
        r_sh[dy][1] <= w_col[dy];
      end
    end
  end

  always_comb begin
    for (int dy = 0; dy < 3; dy++) begin
      w_grid[dy][0] = r_sh[dy][0];
      w_grid[dy][1] = r_sh[dy][1];
      w_grid[dy][2] = w_col[dy];
    end
  end

  // ---------------- centre q = p - (N+1) ----------------
  always_comb begin
    w_qv = (r_row > CW'(1)) || (r_row == CW'(1) && r_col != '0);
    if (r_col != '0) begin
      w_cr = r_row - CW'(1);
      w_cc = r_col - CW'(1);
    end else begin
      w_cr = r_row - CW'(2);
      w_cc = LAST;
    end
    if (SAME) begin
      w_emit = w_qv;
      w_last = (w_cr == LAST) && (w_cc == LAST);
    end else begin
      w_emit = w_qv && (w_cr >= CW'(1)) && (w_cr <= CW'(N - 2))
                    && (w_cc >= CW'(1)) && (w_cc <= CW'(N - 2));
      w_last = (w_cr == CW'(N - 2)) && (w_cc == CW'(N - 2));
    end
  end

  // ---------------- padding mask ----------------
  // Out-of-image taps also cover the shift array's row wrap and stale line
  // buffer rows from the previous frame.
  always_comb begin
    w_top = (w_cr == '0);
    w_bot = (w_cr == LAST);
    w_lft = (w_cc == '0);
    w_rgt = (w_cc == LAST);
    w_mask         = '0;
    w_mask[TAP_TL] = w_top | w_lft;
    w_mask[TAP_TM] = w_top;
    w_mask[TAP_TR] = w_top | w_rgt;
    w_mask[TAP_ML] = w_lft;
    w_mask[TAP_C]  = 1'b0;
    w_mask[TAP_MR] = w_rgt;
    w_mask[TAP_BL] = w_bot | w_lft;
    w_mask[TAP_BM] = w_bot;
    w_mask[TAP_BR] = w_bot | w_rgt;
    if (!SAME) w_mask = '0;
  end

  always_comb begin
    w_win = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          w_win[fm_tap_off(k, 3 * dy + dx, DATA_WIDTH) +: DATA_WIDTH] =
            w_mask[3 * dy + dx] ? '0 : w_grid[dy][dx][k * DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      window_out <= '0;
    end else begin
      valid_out  <= w_adv && w_emit;
      frame_done <= w_adv && w_emit && w_last;
      if (w_adv && w_emit) window_out <= w_win;
    end
  end

endmodule

// File: tb/tb_featuremap_window_gen.sv
// Directed bench: four instances (same N=4, valid N=4, same N=5, same N=3),
// exercised one at a time against a coordinate-based window model.
module tb_featuremap_window_gen;
  import fm_pkg::*;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int PW = CH * DW;
  localparam int WW = CH * 9 * DW;
  localparam int ND = 4;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [PW-1:0] din   [ND];
  logic          vin   [ND];
  logic          rdy   [ND];
  logic [WW-1:0] win   [ND];
  logic          vout  [ND];
  logic          fdone [ND];

  int checks = 0;
  int errors = 0;

  int cur, n, pix, fl, tag;
  bit same;
  int nwin, nfd, lowcnt, first_p, fd_p;
  logic [WW-1:0] first_win, fd_win;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    featuremap_window_gen #(
      .DATA_WIDTH(DW),
      .CHANNELS  (CH),
      .IMG_SIZE  (g == 2 ? 5 : (g == 3 ? 3 : 4)),
      .PAD_MODE  (g == 1 ? PAD_VALID : PAD_SAME)
    ) u_dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .data_in   (din[g]),
      .valid_in  (vin[g]),
      .in_ready  (rdy[g]),
      .window_out(win[g]),
      .valid_out (vout[g]),
      .frame_done(fdone[g])
    );
  end

  function automatic logic [DW-1:0] pval(input int k, input int t, input int r, input int c);
    return DW'(k * 256 + t * 32 + r * n + c);
  endfunction

  // Expected window from image coordinates; out-of-image taps are zero.
  function automatic logic [WW-1:0] model(input int cr, input int cc, input int t);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < CH; k++)
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++) begin
          int r, c;
          r = cr + dy - 1;
          c = cc + dx - 1;
          if (r >= 0 && r < n && c >= 0 && c < n)
            w[(k * 9 + dy * 3 + dx) * DW +: DW] = pval(k, t, r, c);
        end
    return w;
  endfunction

  function automatic logic [9*DW-1:0] mk9(input int t0, input int t1, input int t2,
                                          input int t3, input int t4, input int t5,
                                          input int t6, input int t7, input int t8);
    return {DW'(t8), DW'(t7), DW'(t6), DW'(t5), DW'(t4), DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
  endfunction

  task automatic chk(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clear_counts();
    nwin = 0; nfd = 0; lowcnt = 0; first_p = -1; fd_p = -1;
    first_win = '0; fd_win = '0;
  endtask

  task automatic do_reset(input int t);
    Rst = 1'b1;
    vin[cur] = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    vin[cur] = 1'b0;
    chki("rst_valid_out", 32'(vout[cur]), 32'd0);
    chki("rst_frame_done", 32'(fdone[cur]), 32'd0);
    chk("rst_window_out", win[cur], '0);
    chki("rst_in_ready", 32'(rdy[cur]), 32'd1);
    pix = 0; fl = 0; tag = t;
  endtask

  task automatic select(input int g);
    cur = g;
    n = (g == 2) ? 5 : ((g == 3) ? 3 : 4);
    same = (g != 1);
    clear_counts();
    do_reset(0);
  endtask

  // One clock: present pixel pix, then check outputs against the model.
  task automatic drive(input bit v);
    bit acc, adv, emit, efd;
    int p_adv, q, cr, cc;
    chki("in_ready", 32'(rdy[cur]), 32'(fl == 0));
    for (int k = 0; k < CH; k++) din[cur][k * DW +: DW] = pval(k, tag, pix / n, pix % n);
    vin[cur] = v;
    acc   = v && (fl == 0);
    adv   = acc || (fl > 0);
    p_adv = acc ? pix : n * n + (n + 1 - fl);
    if (fl > 0) lowcnt++;
    @(posedge Clk); #1;
    emit = 0; efd = 0; cr = 0; cc = 0;
    if (adv) begin
      q = p_adv - n - 1;
      if (q >= 0) begin
        cr = q / n;
        cc = q % n;
        if (same) begin
          emit = 1;
          efd  = (cr == n - 1) && (cc == n - 1);
        end else begin
          emit = (cr >= 1) && (cr <= n - 2) && (cc >= 1) && (cc <= n - 2);
          efd  = (cr == n - 2) && (cc == n - 2);
        end
      end
    end
    chki("valid_out", 32'(vout[cur]), 32'(emit));
    chki("frame_done", 32'(fdone[cur]), 32'(efd));
    if (emit) chk("window", win[cur], model(cr, cc, tag));
    if (vout[cur] === 1'b1) begin
      if (nwin == 0) begin
        first_win = win[cur];
        first_p   = p_adv;
      end
      nwin++;
    end
    if (fdone[cur] === 1'b1) begin
      nfd++;
      fd_win = win[cur];
      fd_p   = p_adv;
    end
    if (acc) begin
      if (pix == n * n - 1) begin
        pix = 0;
        if (same) fl = n + 1;
        else      tag++;
      end else begin
        pix++;
      end
    end else if (fl > 0) begin
      fl--;
      if (fl == 0) tag++;
    end
    vin[cur] = 1'b0;
  endtask

  task automatic run(input int target, input bit gaps, input int maxc);
    for (int i = 0; i < maxc && nfd < target; i++)
      drive(gaps ? 1'($urandom_range(0, 1)) : 1'b1);
    chki("frames_done", nfd, target);
  endtask

  initial begin
    for (int g = 0; g < ND; g++) begin
      din[g] = '0;
      vin[g] = 1'b0;
    end

    // ---- same mode, N=4: full frame, hand vectors ----
    select(0);
    run(1, 1'b0, 200);
    chki("s4_windows", nwin, 16);
    chki("s4_ready_low", lowcnt, 5);
    chki("s4_first_p", first_p, 5);
    chk("s4_first_win", first_win,
        {mk9(0, 0, 0, 0, 256, 257, 0, 260, 261), mk9(0, 0, 0, 0, 0, 1, 0, 4, 5)});
    chk("s4_last_win", fd_win,
        {mk9(266, 267, 0, 270, 271, 0, 0, 0, 0), mk9(10, 11, 0, 14, 15, 0, 0, 0, 0)});

    // valid_in held high through the flush, second frame follows directly
    run(2, 1'b0, 200);
    chki("s4_two_frames_windows", nwin, 32);
    chki("s4_two_frames_ready_low", lowcnt, 10);

    // reset at pixel 7, then a clean frame
    for (int i = 0; i < 7; i++) drive(1'b1);
    do_reset(5);
    clear_counts();
    run(1, 1'b0, 200);
    chki("s4_after_rst_windows", nwin, 16);
    chki("s4_after_rst_first_p", first_p, 5);

    // reset in the middle of the flush, then a clean frame
    for (int i = 0; i < 60 && fl != 3; i++) drive(1'b1);
    chki("s4_reached_flush", fl, 3);
    do_reset(7);
    clear_counts();
    run(1, 1'b0, 200);
    chki("s4_after_flush_rst_windows", nwin, 16);

    // ---- valid mode, N=4 ----
    select(1);
    run(1, 1'b0, 100);
    chki("v4_windows", nwin, 4);
    chki("v4_first_p", first_p, 10);
    chki("v4_done_p", fd_p, 15);
    chki("v4_ready_low", lowcnt, 0);
    chk("v4_first_win", first_win,
        {mk9(256, 257, 258, 260, 261, 262, 264, 265, 266), mk9(0, 1, 2, 4, 5, 6, 8, 9, 10)});
    run(2, 1'b0, 100);
    chki("v4_two_frames_windows", nwin, 8);

    // ---- same mode, N=5, random valid_in gaps ----
    select(2);
    run(1, 1'b1, 600);
    chki("s5_gap_windows", nwin, 25);
    chki("s5_gap_ready_low", lowcnt, 6);

    // ---- same mode, N=3, back-to-back frames ----
    select(3);
    for (int f = 1; f <= 3; f++) begin
      run(f, 1'b0, 100);
      chki("s3_frame_windows", nwin, 9 * f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
